// File: rtl/mvm_out_requant.sv
// Requantizes the signed 16-bit mvm3 result stream to signed 8 bits (optional ReLU,
// rounding shift, saturation), buffers it in a small FIFO and tags vector ends.
module mvm_out_requant #(
   parameter int DEPTH    = 4,
   parameter int LOGDEPTH = 2,
   parameter int SHIFT    = 4,
   parameter int RELU     = 1,
   parameter int VEC_LEN  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [15:0] data_in,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  data_out,
   output logic        m_last,
   output logic [7:0]  sat_count
);

   localparam int VW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

   typedef logic [LOGDEPTH-1:0] ptr_t;
   typedef logic [LOGDEPTH:0]   occ_t;
   typedef logic [VW-1:0]       vec_t;

   localparam occ_t DEPTH_C  = occ_t'(DEPTH);
   localparam vec_t VEC_LAST = vec_t'(VEC_LEN - 1);
   // Half an LSB of the shifted result; zero when SHIFT = 0 so the shift is a pass-through.
   localparam logic signed [16:0] RND = 17'((1 << SHIFT) >> 1);

   ptr_t       wr_ptr_q, wr_ptr_d;
   ptr_t       rd_ptr_q, rd_ptr_d;
   occ_t       occ_q, occ_d;
   occ_t       occ_rem;
   vec_t       vec_q, vec_d;
   logic [7:0] sat_q, sat_d;
   logic       m_valid_q, m_valid_d;
   logic [7:0] data_out_q, data_out_d;
   logic       m_last_q, m_last_d;
   logic [8:0] mem_q [DEPTH];

   logic              accept;
   logic              rd;
   logic signed [16:0] v_s;
   logic signed [16:0] sum_s;
   logic signed [16:0] shr_s;
   logic              sat_hi;
   logic              sat_lo;
   logic [7:0]        q_byte;
   logic [8:0]        entry;

   // No write-through: a full FIFO refuses input even when a read happens this cycle.
   assign s_ready = (occ_q < DEPTH_C) && !reset;
   assign accept  = s_valid && s_ready;
   assign rd      = m_valid_q && m_ready;

   // Arithmetic runs in 17 bits so the rounding bias cannot wrap 32767.
   always_comb begin
      v_s    = (RELU != 0 && data_in[15]) ? '0 : {data_in[15], data_in};
      sum_s  = v_s + RND;
      shr_s  = sum_s >>> SHIFT;
      sat_hi = shr_s > 17'sd127;
      sat_lo = shr_s < -17'sd128;
      if (sat_hi)      q_byte = 8'h7f;
      else if (sat_lo) q_byte = 8'h80;
      else             q_byte = shr_s[7:0];
      entry = {(vec_q == VEC_LAST), q_byte};
   end

   // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      vec_d      = vec_q;
      sat_d      = sat_q;
      m_valid_d  = m_valid_q;
      data_out_d = data_out_q;
      m_last_d   = m_last_q;

      if (accept) begin
         wr_ptr_d = wr_ptr_q + ptr_t'(1);
         vec_d    = (vec_q == VEC_LAST) ? '0 : vec_q + vec_t'(1);
         if ((sat_hi || sat_lo) && sat_q != 8'hff) sat_d = sat_q + 8'd1;
      end
      if (rd) rd_ptr_d = rd_ptr_q + ptr_t'(1);

      case ({accept, rd})
         2'b10:   occ_d = occ_q + occ_t'(1);
         2'b01:   occ_d = occ_q - occ_t'(1);
         default: occ_d = occ_q;
      endcase

      // The head register only sees words written on earlier edges: one cycle of latency.
      occ_rem   = occ_q - occ_t'(rd);
      m_valid_d = (occ_rem != '0);
      if (m_valid_d) {m_last_d, data_out_d} = mem_q[rd_ptr_d];
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         vec_q      <= '0;
         sat_q      <= '0;
         m_valid_q  <= 1'b0;
         data_out_q <= '0;
         m_last_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         vec_q      <= vec_d;
         sat_q      <= sat_d;
         m_valid_q  <= m_valid_d;
         data_out_q <= data_out_d;
         m_last_q   <= m_last_d;
      end
   end

   // NOTE: storage is not reset; occupancy guarantees no entry is read before it is written.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= entry;
   end

   assign m_valid   = m_valid_q;
   assign data_out  = data_out_q;
   assign m_last    = m_last_q;
   assign sat_count = sat_q;

endmodule

// File: tb/tb_mvm_out_requant.sv
// Bench for mvm_out_requant: a ReLU instance and a linear instance share one stimulus
// stream; a scoreboard queue holds expected bytes for both.
module tb_mvm_out_requant;

   logic        clk;
   logic        reset;
   logic        s_valid;
   logic        m_ready;
   logic [15:0] data_in;
   logic        s_ready0, s_ready1;
   logic        m_valid0, m_valid1;
   logic [7:0]  data_out0, data_out1;
   logic        m_last0, m_last1;
   logic [7:0]  sat0, sat1;

   mvm_out_requant dut_relu (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready0), .data_in(data_in),
      .m_valid(m_valid0), .m_ready(m_ready), .data_out(data_out0), .m_last(m_last0),
      .sat_count(sat0));

   mvm_out_requant #(.RELU(0)) dut_lin (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready1), .data_in(data_in),
      .m_valid(m_valid1), .m_ready(m_ready), .data_out(data_out1), .m_last(m_last1),
      .sat_count(sat1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] e_relu;
      logic [7:0] e_lin;
      bit         last;
   } exp_t;

   typedef struct {
      logic [15:0] din;
      logic [7:0]  e_relu;
      logic [7:0]  e_lin;
      bit          s_relu;
      bit          s_lin;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[9];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   vec_n    = 0;
   int   occ      = 0;
   int   exp_sat0 = 0;
   int   exp_sat1 = 0;
   bit   rnd_done;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: ReLU, round-half-up shift by 4, saturate. Returns {saturated, byte}.
   function automatic logic [8:0] requant(input int d, input bit relu);
      int v;
      int r;
      logic [7:0] b;
      v = (relu && d < 0) ? 0 : d;
      r = (v + 8) >>> 4;
      if (r > 127)  return {1'b1, 8'h7f};
      if (r < -128) return {1'b1, 8'h80};
      b = r[7:0];
      return {1'b0, b};
   endfunction

   // Monitor: inputs change just after posedge, so the negedge view predicts the next edge.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         occ = 0;
      end else begin
         check("s_ready_vs_occ", int'(s_ready0), int'(occ < 4));
         check("s_ready_match", int'(s_ready1), int'(s_ready0));
         check("m_valid_match", int'(m_valid1), int'(m_valid0));
         if (m_valid0 && m_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", int'(m_valid0), 0);
            end else begin
               e = sb.pop_front();
               check("data_relu", int'(data_out0), int'(e.e_relu));
               check("data_lin", int'(data_out1), int'(e.e_lin));
               check("last_relu", int'(m_last0), int'(e.last));
               check("last_lin", int'(m_last1), int'(e.last));
            end
         end
         occ = occ + int'(s_valid && s_ready0) - int'(m_valid0 && m_ready);
         check("occ_le_depth", int'(occ <= 4), 1);
      end
   end

   task automatic send(input logic [15:0] d, input logic [7:0] e0, input logic [7:0] e1,
                       input bit s0, input bit s1);
      exp_t e;
      int   waited = 0;
      s_valid = 1'b1;
      data_in = d;
      @(negedge clk);
      while (!s_ready0 && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!s_ready0) begin
         check("accept_timeout", int'(s_ready0), 1);
      end else begin
         e.e_relu = e0;
         e.e_lin  = e1;
         e.last   = (vec_n == 2);
         sb.push_back(e);
         vec_n = (vec_n == 2) ? 0 : vec_n + 1;
         if (s0 && exp_sat0 < 255) exp_sat0++;
         if (s1 && exp_sat1 < 255) exp_sat1++;
      end
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic send_model(input logic [15:0] d);
      logic [8:0] r0;
      logic [8:0] r1;
      r0 = requant(int'($signed(d)), 1'b1);
      r1 = requant(int'($signed(d)), 1'b0);
      send(d, r0[7:0], r1[7:0], r0[8], r1[8]);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || m_valid0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", sb.size(), 0);
      check("drain_m_valid", int'(m_valid0), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_sat();
      check("sat_relu", int'(sat0), exp_sat0);
      check("sat_lin", int'(sat1), exp_sat1);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      s_valid = 1'b0;
      sb.delete();
      vec_n    = 0;
      exp_sat0 = 0;
      exp_sat1 = 0;
      @(negedge clk);
      check("s_ready_in_reset", int'(s_ready0), 0);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic post_reset_checks();
      @(negedge clk);
      check("rst_m_valid", int'(m_valid0), 0);
      check("rst_m_last", int'(m_last0), 0);
      check("rst_data_out", int'(data_out0), 0);
      check("rst_sat_relu", int'(sat0), 0);
      check("rst_sat_lin", int'(sat1), 0);
      check("rst_s_ready", int'(s_ready0), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0] = '{16'd100,      8'd6,   8'd6,   1'b0, 1'b0};
      tbl[1] = '{16'(-50),     8'd0,   8'hfd,  1'b0, 1'b0};
      tbl[2] = '{16'd3000,     8'd127, 8'd127, 1'b1, 1'b1};
      tbl[3] = '{16'd24,       8'd2,   8'd2,   1'b0, 1'b0};
      tbl[4] = '{16'd23,       8'd1,   8'd1,   1'b0, 1'b0};
      tbl[5] = '{16'd32767,    8'd127, 8'd127, 1'b1, 1'b1};
      tbl[6] = '{16'(-3000),   8'd0,   8'h80,  1'b0, 1'b1};
      tbl[7] = '{16'(-8),      8'd0,   8'd0,   1'b0, 1'b0};
      tbl[8] = '{16'(-9),      8'd0,   8'hff,  1'b0, 1'b0};

      s_valid = 1'b0;
      m_ready = 1'b1;
      data_in = '0;
      reset   = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      post_reset_checks();

      // Table vectors, three words per group, fresh reset per group.
      for (int i = 0; i < 9; i++) begin
         if (i % 3 == 0) do_reset();
         send(tbl[i].din, tbl[i].e_relu, tbl[i].e_lin, tbl[i].s_relu, tbl[i].s_lin);
         if (i % 3 == 2) begin
            wait_drain();
            check_sat();
         end
      end

      // Backpressure: FIFO fills at 4, head holds, then drains in order.
      do_reset();
      m_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send(16'(16 * i), 8'(i), 8'(i), 1'b0, 1'b0);
      s_valid = 1'b1;
      data_in = 16'd80;
      repeat (3) @(negedge clk);
      check("full_s_ready", int'(s_ready0), 0);
      check("full_m_valid", int'(m_valid0), 1);
      check("full_head_data", int'(data_out0), 1);
      check("full_head_last", int'(m_last0), 0);
      @(posedge clk);
      #1 m_ready = 1'b1;
      send(16'd80, 8'd5, 8'd5, 1'b0, 1'b0);
      send(16'd96, 8'd6, 8'd6, 1'b0, 1'b0);
      wait_drain();

      // Random valid/ready traffic against the model.
      do_reset();
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [15:0] d;
               int idle;
               d    = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                                  : 16'($urandom_range(0, 4095) - 2048);
               idle = $urandom_range(0, 2);
               repeat (idle) begin
                  @(posedge clk);
                  #1;
               end
               send_model(d);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 m_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      m_ready = 1'b1;
      wait_drain();
      check_sat();

      // Reset with two words buffered and the vector counter mid-vector.
      do_reset();
      m_ready = 1'b0;
      send(16'd3000, 8'd127, 8'd127, 1'b1, 1'b1);
      send(16'd32, 8'd2, 8'd2, 1'b0, 1'b0);
      do_reset();
      post_reset_checks();
      m_ready = 1'b1;
      send(16'd16, 8'd1, 8'd1, 1'b0, 1'b0);
      send(16'd32, 8'd2, 8'd2, 1'b0, 1'b0);
      send(16'd48, 8'd3, 8'd3, 1'b0, 1'b0);
      wait_drain();
      check_sat();

      // Saturation counter sticks at 255.
      do_reset();
      for (int i = 0; i < 260; i++) send(16'sd32767, 8'd127, 8'd127, 1'b1, 1'b1);
      wait_drain();
      check("sticky_relu", int'(sat0), 255);
      check("sticky_lin", int'(sat1), 255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
